// File: rtl/wb_regfile.sv
// Writeback stage: selects and formats the MEM/WB result, commits it to the
// architectural register file, serves two bypassed read ports and a forward register.
module wb_regfile #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          dataFromMemory_WB,
  input  logic [DATA_W-1:0]          MEMWB_ALU_result_wB,
  input  logic [$clog2(NREGS)-1:0]   MEMWB_Rdst_address_WB,
  input  logic                       MEMWB_memRead_WB,
  input  logic                       MEMWB_WB,
  input  logic [1:0]                 shmnt_WB,
  input  logic                       Pop_WB,
  input  logic [$clog2(NREGS)-1:0]   rs_addr,
  input  logic [$clog2(NREGS)-1:0]   rt_addr,
  output logic [DATA_W-1:0]          rs_data,
  output logic [DATA_W-1:0]          rt_data,
  output logic                       wb_en,
  output logic [$clog2(NREGS)-1:0]   wb_addr,
  output logic [DATA_W-1:0]          wb_data,
  output logic                       fwd_valid,
  output logic [$clog2(NREGS)-1:0]   fwd_addr,
  output logic [DATA_W-1:0]          fwd_data
);

  localparam int unsigned ADDR_W = $clog2(NREGS);
  localparam int unsigned HALF_W = DATA_W / 2;

  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] regs [NREGS];

  // Source select and byte formatting of the writeback word
  always_comb begin
    src     = (MEMWB_memRead_WB || Pop_WB) ? dataFromMemory_WB : MEMWB_ALU_result_wB;
    wb_data = src;
    case (shmnt_WB)
      2'b01:   wb_data = DATA_W'(src[HALF_W-1:0]);
      2'b10:   wb_data = DATA_W'(src[DATA_W-1:HALF_W]);
      2'b11:   wb_data = {{HALF_W{src[HALF_W-1]}}, src[HALF_W-1:0]};
      default: wb_data = src;
    endcase
  end

  assign wb_en   = MEMWB_WB;
  assign wb_addr = MEMWB_Rdst_address_WB;

  // Read ports; the qualifying wb_en keeps X on idle data inputs off the read path
  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    if (wb_en && (rs_addr == wb_addr)) rs_data = wb_data;
    if (wb_en && (rt_addr == wb_addr)) rt_data = wb_data;
  end

  // Register file storage; R0 is an ordinary register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // One-cycle registered copy of the last commit for the forwarding unit
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= ADDR_W'(0);
      fwd_data  <= DATA_W'(0);
    end else begin
      fwd_valid <= wb_en;
      if (wb_en) begin
        fwd_addr <= wb_addr;
        fwd_data <= wb_data;
      end
    end
  end

endmodule
